// File: rtl/mp_add_pkg.sv
// ============================================================================
//  Module  : mp_add_pkg
//  Brief   : Shared types and constants for the byte-serial add sequencer.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mp_add_pkg;

    localparam int ADDER_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index must reach NBYTES-1 and still fit for NBYTES=1.
    function automatic int idx_width(input int nbytes);
        return $clog2(nbytes) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mp_add_sequencer.sv
// ============================================================================
//  Module  : mp_add_sequencer
//  Brief   : Byte-serial multi-precision add/sub controller for an external
//            8-bit adder; carry chains through a register, LSB byte first.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDER_W*NBYTES-1:0] req_a,
    input  logic [ADDER_W*NBYTES-1:0] req_b,
    input  logic                      req_cin,
    input  logic                      req_sub,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ADDER_W*NBYTES-1:0] rsp_sum,
    output logic                      rsp_cout,
    output logic                      rsp_ovf,
    output logic [ADDER_W-1:0]        add_a,
    output logic [ADDER_W-1:0]        add_b,
    output logic                      add_cin,
    input  logic [ADDER_W-1:0]        add_sum,
    input  logic                      add_cout
);

    localparam int DATA_W = ADDER_W * NBYTES;
    localparam int IDX_W  = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   sum_q;
    logic                carry_q;
    logic                ovf_q;
    logic                live_q;
    logic                accept;
    logic                last_byte;
    logic [IDX_W+2:0]    byte_lsb;

    assign accept    = req_valid && req_ready;
    assign last_byte = (idx_q == LAST_IDX);
    assign byte_lsb  = {idx_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_byte) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // live_q keeps req_ready low for the reset edge itself, so it only rises
    // on the first edge after rst_n is released.
    always_comb begin
        req_ready = (state_q == IDLE) && live_q;
        rsp_valid = (state_q == DONE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[byte_lsb +: ADDER_W];
            add_b   = b_q[byte_lsb +: ADDER_W];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                a_q     <= req_a;
                b_q     <= req_sub ? ~req_b : req_b;
                carry_q <= req_cin;
                idx_q   <= '0;
                ovf_q   <= 1'b0;
            end else if (state_q == RUN) begin
                sum_q[byte_lsb +: ADDER_W] <= add_sum;
                carry_q                    <= add_cout;
                idx_q                      <= idx_q + 1'b1;
                if (last_byte) begin
                    ovf_q <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                             (add_sum[ADDER_W-1] != a_q[DATA_W-1]);
                end
            end
        end
    end

    assign rsp_sum  = sum_q;
    assign rsp_cout = carry_q;
    assign rsp_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mp_add_sequencer.sv
// ============================================================================
//  Module  : tb_mp_add_sequencer
//  Brief   : Self-checking bench: directed operations, per-cycle model compare.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mp_add_sequencer;

    localparam int NB = 4;
    localparam int DW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          req_cin = 1'b0;
    logic          req_sub = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_sum;
    logic          rsp_cout;
    logic          rsp_ovf;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;

    int n_cmp  = 0;
    int n_fail = 0;

    mp_add_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Parent-owned 8-bit adder.
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Behavioural model: one outstanding operation, timed in edge numbers.
    int                 cyc  = 0;
    int                 acc  = 0;
    bit                 busy = 1'b0;
    bit                 live = 1'b0;
    logic [DW-1:0]      m_a, m_b;
    logic               m_cin;

    always @(posedge clk) begin
        bit pre_valid;
        bit pre_ready;
        pre_valid = busy && (cyc >= acc + NB);
        pre_ready = !busy && live;
        cyc++;
        if (!rst_n) begin
            busy = 1'b0;
            live = 1'b0;
        end else begin
            if (pre_ready && req_valid) begin
                busy  = 1'b1;
                acc   = cyc;
                m_a   = req_a;
                m_b   = req_sub ? ~req_b : req_b;
                m_cin = req_cin;
            end else if (pre_valid && rsp_ready) begin
                busy = 1'b0;
            end
            live = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [DW:0]             full;
        logic [DW-1:0]           e_sum;
        logic                    e_ovf;
        longint unsigned         mask;
        longint unsigned         part;
        int                      k;
        if (cyc > 0) begin
            chk("req_ready", req_ready, !busy && live);
            chk("rsp_valid", rsp_valid, busy && (cyc >= acc + NB));
            if (busy && (cyc < acc + NB)) begin
                k    = cyc - acc;
                mask = (64'd1 << (8 * k)) - 64'd1;
                part = ((longint'(m_a) & mask) + (longint'(m_b) & mask) + longint'(m_cin)) >> (8 * k);
                chk("add_a", add_a, (m_a >> (8 * k)) & 8'hFF);
                chk("add_b", add_b, (m_b >> (8 * k)) & 8'hFF);
                chk("add_cin", add_cin, part[0]);
            end else begin
                chk("add_idle", {add_a, add_b, add_cin}, 17'd0);
            end
            if (busy && (cyc >= acc + NB)) begin
                full  = {1'b0, m_a} + {1'b0, m_b} + {{DW{1'b0}}, m_cin};
                e_sum = full[DW-1:0];
                e_ovf = (m_a[DW-1] == m_b[DW-1]) && (e_sum[DW-1] != m_a[DW-1]);
                chk("rsp_sum", rsp_sum, e_sum);
                chk("rsp_cout", rsp_cout, full[DW]);
                chk("rsp_ovf", rsp_ovf, e_ovf);
            end
            if (!live) begin
                chk("rst_rsp", {rsp_sum, rsp_cout, rsp_ovf}, '0);
            end
        end
    end

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic cin, input logic sub,
                         input logic [DW-1:0] e_sum, input logic e_cout,
                         input logic e_ovf, input int hold);
        int n;
        int lat;
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = ~a; req_b = ~b;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, NB);
        chk("lit_sum", rsp_sum, e_sum);
        chk("lit_cout", rsp_cout, e_cout);
        chk("lit_ovf", rsp_ovf, e_ovf);
        for (int i = 0; i < hold; i++) begin
            req_valid = i[0];
            @(posedge clk); #1;
            chk("hold_sum", rsp_sum, e_sum);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_clear", rsp_valid, 1'b0);
        chk("back_idle", req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_rise", req_ready, 1'b1);

        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
        do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 5);
        do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 0);

        // Abort an operation with reset while it is on byte 2.
        req_a = 32'h11223344; req_b = 32'h55667788; req_cin = 1'b0; req_sub = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_byte2", add_a, 8'h22);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", rsp_valid, 1'b0);
        chk("abort_add", {add_a, add_b, add_cin}, 17'd0);
        chk("abort_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", req_ready, 1'b1);

        do_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
